clk_div_ctrl: RTL and testbench

- Runtime-programmable clock-divider controller.
- Sequences a divide counter: start/stop with period-aligned shutdown, divisor reconfiguration over a valid/ready handshake, and new divisors applied only at period boundaries, so no runt or stretched div_clk pulses occur.
- Sits between the control/config logic and every consumer of a slow divided clock or tick enable.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_core.sv | 49 ++++
 rtl/clk_div_ctrl.sv | 120 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_ctrl clock-divider slice.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic logic isLegalDiv(input int div, input int maxDiv);
    return (div >= MIN_DIV) && (div <= maxDiv);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered div_clk/tick decode; outputs line up with the cnt value they describe.
module clk_div_core #(
  parameter int DIV_W = 5,
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_wrap,
  output logic             o_div_clk,
  output logic             o_tick
);

  logic             r_active;
  logic [CTR_W-1:0] r_cnt;
  logic             r_divClk;
  logic             r_tick;

  logic             w_wrap;
  logic [CTR_W-1:0] w_nextCnt;
  logic [DIV_W-1:0] w_half;

  assign w_wrap    = r_active && (DIV_W'(r_cnt) == (i_div - DIV_W'(1)));
  assign w_half    = i_div >> 1;
  // A fresh start, a wrap, or leaving the active states all land on cnt=0.
  assign w_nextCnt = (!i_run || !r_active || w_wrap) ? '0 : r_cnt + CTR_W'(1);

  // Decoding the next count keeps div_clk/tick aligned with cnt; at cnt=0 the
  // decode is low for every legal divisor, so a divisor swap at wrap is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_divClk <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_active <= i_run;
      r_cnt    <= w_nextCnt;
      r_divClk <= i_run && (DIV_W'(w_nextCnt) >= w_half);
      r_tick   <= i_run && (w_nextCnt == '0);
    end
  end

  assign o_wrap    = w_wrap;
  assign o_div_clk = r_divClk;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/stop FSM, divisor handshake and pending divisor.
// Optional completed-period counter enabled by defining CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV = 16,
  parameter int DIV_W   = $clog2(MAX_DIV + 1),
  parameter int CTR_W   = $clog2(MAX_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  input  logic             period_clr,
  output logic [15:0]      period_cnt,
`endif
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  state_t           r_state;
  logic [DIV_W-1:0] r_curDiv;
  logic [DIV_W-1:0] r_pendDiv;
  logic             r_pendValid;
  logic             r_cfgErr;
  logic             r_busy;

  state_t           w_nextState;
  logic [DIV_W-1:0] w_nextDiv;
  logic             w_xfer;
  logic             w_legal;
  logic             w_applyNow;
  logic             w_wrap;
  logic             w_run;

  always_comb begin
    w_xfer      = cfg_valid && !r_pendValid;
    w_legal     = isLegalDiv(int'(cfg_div), MAX_DIV);
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (en) w_nextState = RUN;
      RUN:     if (!en) w_nextState = w_wrap ? IDLE : STOP;
      STOP:    if (w_wrap) w_nextState = en ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
    w_run = (w_nextState != IDLE);

    // Divisors only change while idle or on the wrap edge, never mid-period.
    w_applyNow = w_xfer && w_legal && ((r_state == IDLE) || w_wrap);
    w_nextDiv  = r_curDiv;
    if (r_pendValid && w_wrap) begin
      w_nextDiv = r_pendDiv;
    end else if (w_applyNow) begin
      w_nextDiv = cfg_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_curDiv    <= DIV_W'(MAX_DIV);
      r_pendDiv   <= '0;
      r_pendValid <= 1'b0;
      r_cfgErr    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_curDiv <= w_nextDiv;
      r_cfgErr <= w_xfer && !w_legal;
      r_busy   <= w_run;
      if (r_pendValid) begin
        r_pendValid <= !w_wrap;
      end else if (w_xfer && w_legal && !w_applyNow) begin
        r_pendValid <= 1'b1;
        r_pendDiv   <= cfg_div;
      end
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W),
    .CTR_W(CTR_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .i_div    (r_curDiv),
    .o_wrap   (w_wrap),
    .o_div_clk(div_clk),
    .o_tick   (tick)
  );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] r_periodCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periodCnt <= '0;
    end else if (period_clr) begin
      r_periodCnt <= '0;
    end else if (w_wrap && (r_periodCnt != 16'hFFFF)) begin
      r_periodCnt <= r_periodCnt + 16'd1;
    end
  end

  assign period_cnt = r_periodCnt;
`endif

  assign cfg_ready = !r_pendValid;
  assign cfg_err   = r_cfgErr;
  assign busy      = r_busy;
  assign cur_div   = r_curDiv;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized scoreboard bench for clk_div_ctrl against a period-level reference model.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [4:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       div_clk;
  logic       tick;
  logic       busy;
  logic [4:0] cur_div;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic        period_clr;
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    .period_clr(period_clr),
    .period_cnt(period_cnt),
`endif
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_clk   (div_clk),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  typedef struct {
    int cyc;
    bit tick;
    bit divClk;
    bit busy;
    bit ready;
    bit err;
    int curDiv;
    int pc;
  } exp_t;

  exp_t expQ[$];
  int   cycNum = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: running/stopping flags, position inside the period,
  // divisor in use, queued divisor (0 = none) and completed-period count.
  bit mRun, mStop;
  int mPos, mDiv, mPend, mPc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycNum = cycNum + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void resetModel();
    mRun  = 0;
    mStop = 0;
    mPos  = 0;
    mDiv  = 16;
    mPend = 0;
    mPc   = 0;
  endfunction

  // Advance the model by one clock given the inputs of this cycle and
  // push the outputs the DUT must show in the following cycle.
  task automatic applyStimulus(input bit e, input bit v, input int d, input bit clr);
    bit   active, atEnd, xfer, legal, errNext;
    exp_t rec;
    @(posedge clk);
    #1;
    en        = e;
    cfg_valid = v;
    cfg_div   = 5'(d);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    period_clr = clr;
`endif
    active  = mRun || mStop;
    atEnd   = active && (mPos == mDiv - 1);
    xfer    = v && (mPend == 0);
    legal   = (d >= 2) && (d <= 16);
    errNext = xfer && !legal;

    if (clr) mPc = 0;
    else if (atEnd && mPc < 65535) mPc = mPc + 1;

    if (mPend != 0 && atEnd) begin
      mDiv  = mPend;
      mPend = 0;
    end else if (xfer && legal) begin
      if (!active || atEnd) mDiv = d;
      else mPend = d;
    end

    if (!active) begin
      if (e) begin
        mRun = 1;
        mPos = 0;
      end
    end else if (atEnd) begin
      mPos  = 0;
      mRun  = e;
      mStop = 0;
    end else begin
      mPos = mPos + 1;
      if (mRun && !e) begin
        mRun  = 0;
        mStop = 1;
      end
    end

    rec.cyc    = cycNum + 1;
    rec.tick   = mRun && (mPos == 0);
    rec.divClk = (mRun || mStop) && (mPos >= mDiv / 2);
    rec.busy   = mRun || mStop;
    rec.ready  = (mPend == 0);
    rec.err    = errNext;
    rec.curDiv = mDiv;
    rec.pc     = mPc;
    expQ.push_back(rec);
  endtask

  task automatic checkOutput(input exp_t rec);
    bit bad;
    int pcAct;
    pcAct = rec.pc;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    pcAct = int'(period_cnt);
`endif
    bad = (tick !== rec.tick) || (div_clk !== rec.divClk) || (busy !== rec.busy) ||
          (cfg_ready !== rec.ready) || (cfg_err !== rec.err) ||
          (int'(cur_div) != rec.curDiv) || (pcAct != rec.pc);
    checks = checks + 1;
    if (bad) begin
      errors = errors + 1;
      $display("[TB] FAIL cycle %0d: got tick=%b div_clk=%b busy=%b ready=%b err=%b cur_div=%0d pc=%0d, required tick=%b div_clk=%b busy=%b ready=%b err=%b cur_div=%0d pc=%0d",
               rec.cyc, tick, div_clk, busy, cfg_ready, cfg_err, cur_div, pcAct,
               rec.tick, rec.divClk, rec.busy, rec.ready, rec.err, rec.curDiv, rec.pc);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, " busy"}, int'(busy), 0);
    checkVal({tag, " div_clk"}, int'(div_clk), 0);
    checkVal({tag, " tick"}, int'(tick), 0);
    checkVal({tag, " cfg_ready"}, int'(cfg_ready), 1);
    checkVal({tag, " cfg_err"}, int'(cfg_err), 0);
    checkVal({tag, " cur_div"}, int'(cur_div), 16);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    checkVal({tag, " period_cnt"}, int'(period_cnt), 0);
`endif
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    en        = 1'b0;
    cfg_valid = 1'b0;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    period_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    expQ.delete();
    resetModel();
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: each cycle, compare the DUT against the record queued for it.
  initial begin
    exp_t rec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (expQ.size() > 0 && expQ[0].cyc < cycNum) begin
          rec = expQ.pop_front();
          checks = checks + 1;
          errors = errors + 1;
          $display("[TB] FAIL stale record: got unchecked cycle %0d, required cycle %0d", rec.cyc, cycNum);
        end
        if (expQ.size() > 0 && expQ[0].cyc == cycNum) begin
          rec = expQ.pop_front();
          checkOutput(rec);
        end
      end
    end
  end

  initial begin
    bit eLvl;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    period_clr = 1'b0;
`endif
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    // Default divisor, free running.
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 0);
    // Illegal divisors while running.
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 17, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
    // Divisor 5 loaded in idle, then run.
    applyStimulus(0, 1, 5, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0);
    // Divisor 8, then a stop request partway into a period.
    applyStimulus(1, 1, 8, 0);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0);

    // Randomized traffic.
    eLvl = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) eLvl = !eLvl;
      applyStimulus(eLvl, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 20)),
                    ($urandom_range(0, 149) == 0));
    end

    // Get a divisor pending mid-period, then reset.
    for (int i = 0; i < 40 && !(mRun && mPend == 0 && mPos < mDiv - 1); i++)
      applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 4, 0);
    checkVal("pending before reset", mPend, 4);
    doReset();
    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0, (i == 50));
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkVal("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
